tdr_access_controller: RTL and testbench
========================================

Name: tdr_access_controller

Overview:
Digital initiator for the time-domain register (TDR).
- Accepts a digital interval code over a valid/ready request port.
- Writes that interval into the TDR as WE0/WE1 write-enable pulses.
- Issues a read enable, measures the width of the TDR's returned out pulse in clock cycles, and returns the count over a valid/ready response port.
- Sits between the digital control logic and the TDR macro, and is the TDR's only driver.

Parameters:
T0_W, 8, width of the requested pulse-length code (in clock cycles)
CNT_W, 10, width of the measured-count result (saturating)
GAP_CYC, 2, low cycles between the WE0 pulse and the WE1 pulse (≥1)
SETTLE_CYC, 4, idle cycles between the end of WE1 and the assertion of RE (≥1)
RD_TIMEOUT, 1000, maximum cycles spent in the read phase before aborting (< 2^CNT_W)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_t_i  in  T0_W  pulse length in cycles for WE0 and WE1
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_count_o  out  CNT_W  measured cycles that tdr_out_i was high
rsp_timeout_o  out  1  read phase ended by timeout
tdr_rstb_o  out  1  active-low reset to the TDR
we0_o  out  1  TDR write-enable 0
we1_o  out  1  TDR write-enable 1
re_o  out  1  TDR read enable
tdr_out_i  in  1  TDR output pulse (asynchronous to clk_i)

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - state=IDLE, so req_ready_o=1.
  - rsp_valid_o=0, rsp_count_o=0, rsp_timeout_o=0.
  - we0_o=0, we1_o=0, re_o=0.
  - tdr_rstb_o=0, which holds the TDR in reset; it goes to 1 on the first clock after rst_i deasserts.
- All TDR-facing outputs are registered and glitch-free.
- States: IDLE → CLR → WR0 → GAP → WR1 → SETTLE → RD → RESP → IDLE.
- IDLE: a request is accepted on the edge where req_valid_i && req_ready_o. req_t_i is latched at that edge.
- CLR: tdr_rstb_o=0 for exactly 1 cycle.
- WR0: we0_o=1 for exactly req_t cycles.
- GAP: all enables low for GAP_CYC cycles.
- WR1: we1_o=1 for exactly req_t cycles.
- SETTLE: all enables low for SETTLE_CYC cycles.
- req_t=0: WR0, GAP and WR1 are skipped (CLR → SETTLE). The read is still performed.
- RD entry: re_o=1; the high counter and timeout counter clear.
- RD, per cycle:
  - If the sampled tdr_out=1, the count increments; it saturates at 2^CNT_W−1.
  - RD ends on the first sampled 1→0 transition after at least one high sample, with rsp_timeout_o=0.
  - RD also ends after RD_TIMEOUT cycles, with rsp_timeout_o=1.
  - On a timeout the count holds whatever was accumulated.
  - If the transition and the timeout land in the same cycle, the transition wins (timeout=0).
- RESP:
  - re_o=0 and rsp_valid_o=1.
  - rsp_count_o and rsp_timeout_o stay stable until rsp_valid_o && rsp_ready_i.
  - The state returns to IDLE on the next cycle.
  - If rsp_ready_i is already high on the first RESP cycle, the response completes in one cycle.
- New requests are never accepted outside IDLE. req_valid_i held during an operation is ignored until IDLE.
- rst_i mid-operation: everything immediately returns to reset values. Any pulse in progress is truncated and no response is produced.

Optional Feature:
TDR_SYNC_EN
- Defined: tdr_out_i passes through a 2-flop synchronizer before sampling, adding 2 cycles of sampling latency. RD stays in RD for the synchronizer latency before edge detection is allowed.
- Undefined: tdr_out_i is sampled directly by one register, for bench use with a synchronous TDR model only.
- In both builds: a pulse N cycles wide yields count=N.

Test Plan:
- Reset release, no requests → req_ready_o=1, tdr_rstb_o=0 in reset then 1 on the next cycle, all enables 0, rsp_valid_o never asserts.
- Request req_t=5; TDR model returns a 12-cycle out pulse → tdr_rstb_o low 1 cycle, we0 high 5, low 2, we1 high 5, low 4, re high until the falling edge, then rsp_count=12, rsp_timeout=0.
- Request req_t=0; model returns a 3-cycle pulse → no we0/we1 activity, CLR goes straight to SETTLE, rsp_count=3.
- Model never pulses → re_o high for exactly 1000 cycles, rsp_count=0, rsp_timeout=1.
- rsp_ready_i held low for 20 cycles in RESP, with req_valid_i=1 throughout → rsp fields stable, req_ready_o=0; after the handshake the next request is accepted 1 cycle later.
- Assert rst_i mid-WR1 → we1_o drops asynchronously, tdr_rstb_o=0, no response; a subsequent request (req_t=3) completes normally.

Source files
------------

// File: rtl/tdr_access_controller.sv
// TDR initiator: writes an interval via WE0/WE1, reads it back via RE, returns the width.
// Build option TDR_SYNC_EN: 2-flop synchronizer on tdr_out_i ahead of the sample register.
module tdr_access_controller #(
  parameter int T0_W       = 8,
  parameter int CNT_W      = 10,
  parameter int GAP_CYC    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int RD_TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [T0_W-1:0]  req_t_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [CNT_W-1:0] rsp_count_o,
  output logic             rsp_timeout_o,
  output logic             tdr_rstb_o,
  output logic             we0_o,
  output logic             we1_o,
  output logic             re_o,
  input  logic             tdr_out_i
);

  typedef enum logic [2:0] {
    IDLE, CLR, WR0, GAP, WR1, SETTLE, RD, RESP
  } state_t;

  localparam int GW  = $clog2(GAP_CYC + 1);
  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int DW0 = (GW > SW) ? GW : SW;
  localparam int DW  = (T0_W > DW0) ? T0_W : DW0;
  localparam int TW  = $clog2(RD_TIMEOUT + 1);

  // RD cycles whose sample still reflects tdr_out from before RE rose
`ifdef TDR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  state_t state, state_n;

  logic [T0_W-1:0]  t;
  logic [DW-1:0]    dcnt;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] count;
  logic             smp;
  logic             seen;
  logic             tmo;
  logic             done;
  logic             live;
  logic             fall;
  logic             hit;

  assign done = (dcnt == '0);
  assign live = (tcnt >= TW'(LAT));
  assign fall = live && seen && !smp;
  assign hit  = (tcnt == TW'(RD_TIMEOUT - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid_i) state_n = CLR;
      CLR:     state_n = (t == '0) ? SETTLE : WR0;
      WR0:     if (done) state_n = GAP;
      GAP:     if (done) state_n = WR1;
      WR1:     if (done) state_n = SETTLE;
      SETTLE:  if (done) state_n = RD;
      RD:      if (fall || hit) state_n = RESP;
      RESP:    if (rsp_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t <= '0;
    end else if (state == IDLE && req_valid_i) begin
      t <= req_t_i;
    end
  end

  // Phase-length down counter, reloaded on every state change
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dcnt <= '0;
    end else if (state_n != state) begin
      unique case (state_n)
        WR0, WR1: dcnt <= DW'(t) - DW'(1);
        GAP:      dcnt <= DW'(GAP_CYC - 1);
        SETTLE:   dcnt <= DW'(SETTLE_CYC - 1);
        default:  dcnt <= '0;
      endcase
    end else if (!done) begin
      dcnt <= dcnt - DW'(1);
    end
  end

`ifdef TDR_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync <= '0;
      smp  <= 1'b0;
    end else begin
      sync <= {sync[0], tdr_out_i};
      smp  <= sync[1];
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      smp <= 1'b0;
    end else begin
      smp <= tdr_out_i;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt  <= '0;
      count <= '0;
      seen  <= 1'b0;
      tmo   <= 1'b0;
    end else if (state != RD && state_n == RD) begin
      tcnt  <= '0;
      count <= '0;
      seen  <= 1'b0;
      tmo   <= 1'b0;
    end else if (state == RD) begin
      tcnt <= tcnt + TW'(1);
      if (live && smp) begin
        seen <= 1'b1;
        if (count != '1) begin
          count <= count + CNT_W'(1);
        end
      end
      // a falling edge seen on the last allowed cycle still counts as a clean read
      if (state_n == RESP) begin
        tmo <= !fall;
      end
    end
  end

  // TDR-facing strobes are flops decoded from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdr_rstb_o <= 1'b0;
      we0_o      <= 1'b0;
      we1_o      <= 1'b0;
      re_o       <= 1'b0;
    end else begin
      tdr_rstb_o <= (state_n != CLR);
      we0_o      <= (state_n == WR0);
      we1_o      <= (state_n == WR1);
      re_o       <= (state_n == RD);
    end
  end

  assign req_ready_o   = (state == IDLE);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_count_o   = count;
  assign rsp_timeout_o = tmo;

endmodule

// File: tb/tb_tdr_access_controller.sv
// Bench for tdr_access_controller: phase-level reference model checked every cycle,
// plus directed literal checks on counts, pulse widths and reset behaviour.
module tb_tdr_access_controller;

  localparam int T0_W   = 8;
  localparam int CNT_W  = 10;
  localparam int GAP    = 2;
  localparam int SETTLE = 4;
  localparam int TO     = 1000;
`ifdef TDR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [T0_W-1:0]  req_t = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [CNT_W-1:0] rsp_count;
  logic             rsp_timeout;
  logic             tdr_rstb;
  logic             we0;
  logic             we1;
  logic             re;
  logic             tdr_out;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  tdr_access_controller #(
    .T0_W(T0_W), .CNT_W(CNT_W), .GAP_CYC(GAP),
    .SETTLE_CYC(SETTLE), .RD_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_t_i(req_t),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_count_o(rsp_count), .rsp_timeout_o(rsp_timeout),
    .tdr_rstb_o(tdr_rstb), .we0_o(we0), .we1_o(we1), .re_o(re),
    .tdr_out_i(tdr_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
    end
  endtask

  // Synchronous TDR stand-in: pd cycles after RE rises, out is high for pn cycles
  int pd = 1;
  int pn = 0;
  int k  = 0;
  initial begin
    tdr_out = 1'b0;
    forever begin
      @(negedge clk);
      if (re) k++;
      else k = 0;
      tdr_out = (k > pd && k <= pd + pn);
    end
  end

  // Reference model: operation timeline as offsets from the accept edge
  typedef enum {M_IDLE, M_OP, M_RESP} mph_t;
  mph_t mph = M_IDLE;
  int  off = 0, mt = 0, rd0 = 0, rdlen = 0, ecount = 0, hi_end = 0;
  bit  eto = 0, erstb = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mph   = M_IDLE;
      erstb = 0;
    end else begin
      erstb = 1;
      case (mph)
        M_IDLE: if (req_valid) begin
          mph = M_OP;
          off = 0;
          mt  = int'(req_t);
          rd0 = (mt == 0) ? 1 + SETTLE : 1 + 2 * mt + GAP + SETTLE;
          if (pn == 0 || pd + pn + 1 + LAT > TO) begin
            rdlen = TO;
            eto   = 1;
          end else begin
            rdlen = pd + pn + 1 + LAT;
            eto   = 0;
          end
          hi_end = pd + pn + LAT - 1;
          if (hi_end > TO - 1) hi_end = TO - 1;
          ecount = hi_end - (pd + LAT) + 1;
          if (ecount < 0) ecount = 0;
        end
        M_OP: begin
          off++;
          if (off == rd0 + rdlen) mph = M_RESP;
        end
        M_RESP: if (rsp_ready) mph = M_IDLE;
        default: mph = M_IDLE;
      endcase
    end
  end

  bit ew0, ew1, ere, erd, ev;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      ew0 = 0; ew1 = 0; ere = 0; erd = 0; ev = 0;
      case (mph)
        M_IDLE: erd = 1;
        M_OP: begin
          ew0 = mt > 0 && off >= 1 && off <= mt;
          ew1 = mt > 0 && off >= mt + GAP + 1 && off <= 2 * mt + GAP;
          ere = off >= rd0;
        end
        default: ev = 1;
      endcase
      chk("req_ready", req_ready, erd);
      chk("rsp_valid", rsp_valid, ev);
      chk("we0", we0, ew0);
      chk("we1", we1, ew1);
      chk("re", re, ere);
      chk("tdr_rstb", tdr_rstb, (mph == M_OP && off == 0) ? 0 : erstb);
      if (mph == M_RESP) begin
        chk("rsp_count", rsp_count, ecount);
        chk("rsp_timeout", rsp_timeout, eto);
      end
    end
  end

  int w0c = 0, w1c = 0, rec = 0, rbc = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (we0) w0c++;
      if (we1) w1c++;
      if (re) rec++;
      if (!tdr_rstb) rbc++;
    end
  end

  // Tasks are entered and left one time unit after a falling edge
  task automatic start_req(input int t, input int d, input int n, input bit keep);
    pd = d; pn = n;
    w0c = 0; w1c = 0; rec = 0; rbc = 0;
    req_t = T0_W'(t);
    req_valid = 1'b1;
    @(negedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int g = 0;
    while (!rsp_valid && g < 3000) begin
      @(negedge clk); #1;
      g++;
    end
    if (!rsp_valid) chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic handshake(input int hold, output logic [CNT_W-1:0] c, output logic tm);
    repeat (hold) begin
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    c  = rsp_count;
    tm = rsp_timeout;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [CNT_W-1:0] c;
  logic             tm;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rstb", tdr_rstb, 0);
    chk("rst_we", {we0, we1, re}, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", rsp_count, 0);
    chk("rst_timeout", rsp_timeout, 0);
    rst = 1'b0;
    #1 chk("rstb_hold", tdr_rstb, 0);
    @(posedge clk); #1;
    chk("rstb_release", tdr_rstb, 1);
    repeat (10) @(negedge clk);
    #1;

    start_req(5, 1, 12, 0);
    wait_rsp();
    handshake(0, c, tm);
    chk("t5_count", c, 12);
    chk("t5_timeout", tm, 0);
    chk("t5_we0_len", w0c, 5);
    chk("t5_we1_len", w1c, 5);
    chk("t5_clr_len", rbc, 1);
    chk("t5_re_len", rec, 12 + 2 + LAT);

    start_req(0, 2, 3, 0);
    wait_rsp();
    handshake(0, c, tm);
    chk("t0_count", c, 3);
    chk("t0_timeout", tm, 0);
    chk("t0_we_len", w0c + w1c, 0);

    start_req(1, 1, 0, 0);
    wait_rsp();
    handshake(2, c, tm);
    chk("to_count", c, 0);
    chk("to_flag", tm, 1);
    chk("to_re_len", rec, 1000);

    start_req(4, 3, 7, 1);
    wait_rsp();
    repeat (20) begin
      @(negedge clk); #1;
    end
    chk("hold_ready", req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_idle", req_ready, 1);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_accept", req_ready, 0);
    #1 req_valid = 1'b0;
    wait_rsp();
    handshake(0, c, tm);
    chk("hold2_count", c, 7);

    start_req(6, 1, 4, 0);
    begin
      int g = 0;
      while (!we1 && g < 100) begin
        @(negedge clk); #1;
        g++;
      end
      chk("reach_wr1", we1, 1);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("mid_rst_we1", we1, 0);
    chk("mid_rst_rstb", tdr_rstb, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_release", tdr_rstb, 1);
    repeat (3) @(negedge clk);
    #1;

    start_req(3, 1, 5, 0);
    wait_rsp();
    handshake(1, c, tm);
    chk("t3_count", c, 5);
    chk("t3_timeout", tm, 0);
    chk("t3_we0_len", w0c, 3);
    chk("t3_we1_len", w1c, 3);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d miscompares so far, required completion", errors);
    $fatal(1);
  end

endmodule
